// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM state type and word geometry.
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } loader_state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Host byte stream, load control and instruction-memory write port of the loader.
interface instruction_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  done;

  modport master (
    output start, num_words, in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done
  );

  modport slave (
    input  start, num_words, in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done
  );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes into a 32-bit word, first byte ending up most significant.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[23:0], in_byte};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign last_byte = (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Streams a byte-serial program image into instruction memory, one word per write,
// holding the CPU stalled until the whole image has been written.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input logic                  clk,
  input logic                  rst_n,
  instruction_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0]   Depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CountOne = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic        accept;
  logic        clear_bytes;
  logic        last_byte;
  logic        last_word;
  logic [31:0] word;

  assign accept    = (state_q == StRecv) && bus.in_valid;
  assign last_word = ({1'b0, addr_q} == (count_q - CountOne));

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .clear     (clear_bytes),
    .in_byte   (bus.in_byte),
    .word      (word),
    .last_byte (last_byte)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    clear_bytes = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.num_words == '0) begin
            state_d = StDone;
          end else begin
            state_d     = StRecv;
            // Oversized images are truncated so the address never wraps onto word 0.
            count_d     = (bus.num_words > Depth) ? Depth : bus.num_words;
            addr_d      = '0;
            clear_bytes = 1'b1;
          end
        end
      end
      StRecv: begin
        if (accept && last_byte) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          state_d     = StRecv;
          addr_d      = addr_q + AddrOne;
          clear_bytes = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // Every output is decoded from registers only, so in_ready never depends on in_valid.
  assign bus.in_ready  = (state_q == StRecv);
  assign bus.mem_we    = (state_q == StWrite);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word;
  assign bus.cpu_hold  = (state_q == StRecv) || (state_q == StWrite);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_instruction_loader.sv
// Randomised bench for instruction_loader: drives byte streams and compares the observed
// memory writes and status outputs with a stream-level model of the program image.
module tb_instruction_loader;
  import loader_pkg::*;

  localparam int unsigned AW    = DEFAULT_ADDR_WIDTH;
  localparam int          Depth = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_loader #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stim [0:255];
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          done_cnt;
  int          done_cyc;
  int          first_rdy;
  int          bytes_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) stim[i] = 8'($urandom);
  endtask

  // mode 0: in_valid always high, 1: every other cycle, 2: random.
  // abort_bytes >= 0 pulls reset right after that many bytes have been accepted.
  task automatic run_load(input int n, input int mode, input int restart_cyc,
                          input int abort_bytes);
    int idx;
    int total;
    bit v;
    bit exp_hold;
    idx       = 0;
    total     = 4 * n;
    done_cnt  = 0;
    done_cyc  = -1;
    first_rdy = -1;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_words = (AW + 1)'(n);
    bus.in_valid  = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == restart_cyc);
      if (cyc == restart_cyc) bus.num_words = (AW + 1)'($urandom_range(1, 40));
      if (bus.mem_we) begin
        wr_addr_q.push_back(int'(bus.mem_addr));
        wr_data_q.push_back(bus.mem_wdata);
        check_eq("ready_low_in_write", 64'(bus.in_ready), 64'(0));
      end
      if (bus.in_ready && first_rdy < 0) first_rdy = cyc;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      exp_hold = (n > 0) && (done_cyc < 0);
      check_eq("cpu_hold", 64'(bus.cpu_hold), 64'(exp_hold));
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      v            = v && (idx < total);
      bus.in_valid = v;
      bus.in_byte  = v ? stim[idx] : 8'($urandom);
      if (v && bus.in_ready) begin
        idx++;
        if (idx == abort_bytes) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          #1;
          check_eq("outputs_in_reset",
                   64'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                        bus.cpu_hold, bus.done}), 64'(0));
          bus.in_valid = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check_eq("no_write_in_reset", 64'(bus.mem_we), 64'(0));
          end
          rst_n     = 1'b1;
          bytes_acc = idx;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bytes_acc    = idx;
  endtask

  task automatic verify(input string name, input int n, input int mode);
    int ne;
    ne = (n > Depth) ? Depth : n;
    check_eq({name, "_nwrites"}, 64'(wr_addr_q.size()), 64'(ne));
    for (int i = 0; i < wr_addr_q.size() && i < ne; i++) begin
      check_eq({name, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
      check_eq({name, "_data"}, 64'(wr_data_q[i]),
               64'({stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]}));
    end
    check_eq({name, "_done_count"}, 64'(done_cnt), 64'(1));
    check_eq({name, "_bytes_taken"}, 64'(bytes_acc), 64'(4 * ne));
    if (ne > 0) check_eq({name, "_first_ready"}, 64'(first_rdy), 64'(1));
    else        check_eq({name, "_ready_never"}, 64'(first_rdy), 64'(-1));
    if (mode == 0) check_eq({name, "_done_cycle"}, 64'(done_cyc), 64'(5 * ne + 1));
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.num_words = '0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs",
             64'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                  bus.cpu_hold, bus.done}), 64'(0));
    rst_n = 1'b1;

    stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
    run_load(1, 0, 0, -1);
    verify("one_word", 1, 0);
    check_eq("one_word_literal", 64'(wr_data_q.size() > 0 ? wr_data_q[0] : 32'h0),
             64'(32'h2008_0005));

    fill_random(12);
    run_load(3, 1, 0, -1);
    verify("toggle", 3, 1);

    run_load(0, 0, 0, -1);
    verify("zero", 0, 0);

    fill_random(160);
    run_load(40, 0, 0, -1);
    verify("saturate", 40, 0);

    fill_random(12);
    run_load(3, 0, 0, 6);
    check_eq("abort_nwrites", 64'(wr_addr_q.size()), 64'(1));
    if (wr_data_q.size() > 0)
      check_eq("abort_word0", 64'(wr_data_q[0]), 64'({stim[0], stim[1], stim[2], stim[3]}));
    repeat (2) begin
      @(negedge clk);
      check_eq("idle_after_reset", 64'({bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done}),
               64'(0));
    end
    fill_random(4);
    run_load(1, 0, 0, -1);
    verify("after_reset", 1, 0);

    fill_random(16);
    run_load(4, 2, 2, -1);
    verify("restart_ignored", 4, 2);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      fill_random(4 * n);
      run_load(n, 2, 0, -1);
      verify("random", n, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
